// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, drives the instruction
// memory address, and registers the fetched word into the IF/ID pipeline
// register. A small RUN/HALTED machine stops fetching after a HALT opcode
// until a taken branch redirects the PC.
module instruction_fetch #(
  parameter int                           ADDRESSWIDTH      = 32,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESSWIDTH-1:0]      RESET_PC          = '0,
  parameter logic [5:0]                   HALT_OPCODE       = 6'h11,
  parameter logic [INSTRUCTION_WIDTH-1:0] INVALID_WORD      = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_i,
  input  logic                         branch_taken_i,
  input  logic [ADDRESSWIDTH-1:0]      branch_target_i,
  output logic [ADDRESSWIDTH-1:0]      imem_addr_o,
  output logic                         imem_branch_taken_o,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instr_i,
  output logic [INSTRUCTION_WIDTH-1:0] if_id_instr_o,
  output logic [ADDRESSWIDTH-1:0]      if_id_pc_o,
  output logic                         if_id_valid_o,
  output logic                         halted_o,
  output logic                         fetch_err_o,
  output logic [31:0]                  fetch_count_o
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                         state_reg, state_next;
  logic [ADDRESSWIDTH-1:0]        pc_reg, pc_next;
  logic [INSTRUCTION_WIDTH-1:0]   instr_reg, instr_next;
  logic [ADDRESSWIDTH-1:0]        ifid_pc_reg, ifid_pc_next;
  logic                           valid_reg, valid_next;
  logic                           err_reg, err_next;
  logic [31:0]                    count_reg, count_next;

  // Decoded properties of the word currently returned by memory.
  logic                           word_invalid;
  logic                           word_halt;
  logic [ADDRESSWIDTH-1:0]        pc_plus4;
  logic [31:0]                    count_inc;

  assign word_invalid = (imem_instr_i == INVALID_WORD);
  assign word_halt    = (imem_instr_i[31:26] == HALT_OPCODE);
  assign pc_plus4     = pc_reg + ADDRESSWIDTH'(4);
  // Saturating increment: the count sticks at all-ones rather than wrapping.
  assign count_inc    = (count_reg == 32'hFFFF_FFFF) ? count_reg : count_reg + 32'd1;

  // Memory address and suppress strobe follow the PC and branch input directly.
  assign imem_addr_o         = pc_reg;
  assign imem_branch_taken_o = branch_taken_i;

  assign if_id_instr_o = instr_reg;
  assign if_id_pc_o    = ifid_pc_reg;
  assign if_id_valid_o = valid_reg;
  assign halted_o      = (state_reg == HALTED);
  assign fetch_err_o   = err_reg;
  assign fetch_count_o = count_reg;

  // Next-state logic: redirect beats stall beats normal advance, in both states.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    ifid_pc_next = ifid_pc_reg;
    valid_next   = valid_reg;
    err_next     = err_reg;
    count_next   = count_reg;

    if (branch_taken_i) begin
      // Redirect: the word in flight belongs to the wrong path, squash it.
      state_next   = RUN;
      pc_next      = branch_target_i;
      instr_next   = '0;
      ifid_pc_next = '0;
      valid_next   = 1'b0;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (!stall_i) begin
            if (word_invalid) begin
              // Misaligned or otherwise bad fetch: bubble, flag it, keep going.
              instr_next   = '0;
              ifid_pc_next = pc_reg;
              valid_next   = 1'b0;
              pc_next      = pc_plus4;
              err_next     = 1'b1;
            end else if (word_halt) begin
              // HALT itself is delivered and counted; the PC parks on it.
              instr_next   = imem_instr_i;
              ifid_pc_next = pc_reg;
              valid_next   = 1'b1;
              count_next   = count_inc;
              state_next   = HALTED;
            end else begin
              instr_next   = imem_instr_i;
              ifid_pc_next = pc_reg;
              valid_next   = 1'b1;
              pc_next      = pc_plus4;
              count_next   = count_inc;
            end
          end
        end
        HALTED: begin
          // Stall has no effect here; keep feeding bubbles downstream.
          instr_next   = '0;
          ifid_pc_next = '0;
          valid_next   = 1'b0;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State, PC and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      pc_reg      <= RESET_PC;
      instr_reg   <= '0;
      ifid_pc_reg <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      ifid_pc_reg <= ifid_pc_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      count_reg   <= count_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, redirect
// with stall, HALT and restart, misaligned fetch, PC wrap and async reset.
module tb_instruction_fetch;

  localparam logic [31:0] INVALID = 32'hDEADBEEF;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_branch_taken;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];

  int checks;
  int errors;

  instruction_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .stall_i             (stall),
    .branch_taken_i      (branch_taken),
    .branch_target_i     (branch_target),
    .imem_addr_o         (imem_addr),
    .imem_branch_taken_o (imem_branch_taken),
    .imem_instr_i        (imem_instr),
    .if_id_instr_o       (if_id_instr),
    .if_id_pc_o          (if_id_pc),
    .if_id_valid_o       (if_id_valid),
    .halted_o            (halted),
    .fetch_err_o         (fetch_err),
    .fetch_count_o       (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: returns INVALID for misaligned or suppressed fetches.
  always_comb begin
    if (imem_branch_taken || (imem_addr[1:0] != 2'b00))
      imem_instr = INVALID;
    else
      imem_instr = mem[imem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the whole IF/ID register plus PC and counter in one go.
  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic valid, input logic [31:0] addr, input logic [31:0] cnt);
    check({tag, ".instr"}, {32'd0, if_id_instr}, {32'd0, instr});
    check({tag, ".pc"},    {32'd0, if_id_pc},    {32'd0, pc});
    check({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, valid});
    check({tag, ".addr"},  {32'd0, imem_addr},   {32'd0, addr});
    check({tag, ".count"}, {32'd0, fetch_count}, {32'd0, cnt});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h20010005;
    mem[1] = 32'h20020003;
    mem[2] = 32'h00221820;
    mem[3] = 32'h44000000;   // HALT opcode 0x11

    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    #3;
    check_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
    check("reset.halted", {63'd0, halted}, 64'd0);
    check("reset.err", {63'd0, fetch_err}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Sequential fetch
    tick(); check_ifid("seq0", 32'h20010005, 32'h0, 1'b1, 32'h4, 32'd1);
    tick(); check_ifid("seq1", 32'h20020003, 32'h4, 1'b1, 32'h8, 32'd2);

    // Two-cycle stall at PC=8
    stall = 1'b1;
    tick(); check_ifid("stall0", 32'h20020003, 32'h4, 1'b1, 32'h8, 32'd2);
    tick(); check_ifid("stall1", 32'h20020003, 32'h4, 1'b1, 32'h8, 32'd2);
    stall = 1'b0;
    tick(); check_ifid("seq2", 32'h00221820, 32'h8, 1'b1, 32'hC, 32'd3);

    // HALT at 0x0C, then bubbles; stall is ignored while halted
    tick(); check_ifid("halt", 32'h44000000, 32'hC, 1'b1, 32'hC, 32'd4);
    check("halt.halted", {63'd0, halted}, 64'd1);
    stall = 1'b1;
    tick(); check_ifid("halted_bub", 32'h0, 32'h0, 1'b0, 32'hC, 32'd4);
    check("halted.halted", {63'd0, halted}, 64'd1);
    stall = 1'b0;

    // Branch out of HALTED to 0x20
    branch_taken = 1'b1; branch_target = 32'h20;
    #1; check("br20.strobe", {63'd0, imem_branch_taken}, 64'd1);
    tick(); branch_taken = 1'b0;
    check_ifid("br20_bub", 32'h0, 32'h0, 1'b0, 32'h20, 32'd4);
    check("br20.halted", {63'd0, halted}, 64'd0);
    tick(); check_ifid("br20_fetch", 32'h1000_0008, 32'h20, 1'b1, 32'h24, 32'd5);

    // Move PC to 0x10, then branch+stall to 0x40
    branch_taken = 1'b1; branch_target = 32'h10;
    tick(); branch_taken = 1'b0;
    check("to10.addr", {32'd0, imem_addr}, 64'h10);
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h40;
    #1; check("br40.strobe", {63'd0, imem_branch_taken}, 64'd1);
    tick(); branch_taken = 1'b0; stall = 1'b0;
    check_ifid("br40_bub", 32'h0, 32'h0, 1'b0, 32'h40, 32'd5);
    tick(); check_ifid("br40_fetch", 32'h1000_0010, 32'h40, 1'b1, 32'h44, 32'd6);
    check("br40.strobe_off", {63'd0, imem_branch_taken}, 64'd0);

    // Misaligned target 0x42
    branch_taken = 1'b1; branch_target = 32'h42;
    tick(); branch_taken = 1'b0;
    check("mis.err_before", {63'd0, fetch_err}, 64'd0);
    tick(); check_ifid("mis0", 32'h0, 32'h42, 1'b0, 32'h46, 32'd6);
    check("mis.err", {63'd0, fetch_err}, 64'd1);

    // Redirect to HALT at 0x0C; error stays sticky
    branch_taken = 1'b1; branch_target = 32'hC;
    tick(); branch_taken = 1'b0;
    check("sticky.err", {63'd0, fetch_err}, 64'd1);
    tick(); check_ifid("halt2", 32'h44000000, 32'hC, 1'b1, 32'hC, 32'd7);
    tick(); check("halt2.halted", {63'd0, halted}, 64'd1);

    // Async reset pulse between edges while HALTED with count 7
    #2; rst_n = 1'b0;
    #1;
    check_ifid("areset", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
    check("areset.halted", {63'd0, halted}, 64'd0);
    check("areset.err", {63'd0, fetch_err}, 64'd0);
    rst_n = 1'b1;
    tick(); check_ifid("post_rst", 32'h20010005, 32'h0, 1'b1, 32'h4, 32'd1);

    // PC wraps from 0xFFFFFFFC to 0
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick(); branch_taken = 1'b0;
    tick(); check_ifid("wrap", 32'h1000_003F, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 32, byte-address width of the program counter.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, program counter value after reset.
REQ-004 SHALL have parameter HALT_OPCODE, default 6'h11, opcode field value of the HALT instruction.
REQ-005 SHALL have parameter INVALID_WORD, default 32'hDEADBEEF, word returned by instruction memory for a misaligned or suppressed fetch.
REQ-006 SHALL have the ports below, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard unit request to hold PC and IF/ID.
- branch_taken_i  input  1  resolved taken branch or jump; redirect this cycle.
- branch_target_i  input  ADDRESSWIDTH  redirect byte address.
- imem_addr_o  output  ADDRESSWIDTH  byte address to instruction memory.
- imem_branch_taken_o  output  1  suppress-fetch strobe to instruction memory.
- imem_instr_i  input  INSTRUCTION_WIDTH  combinational instruction memory read data.
- if_id_instr_o  output  INSTRUCTION_WIDTH  registered instruction to decode.
- if_id_pc_o  output  ADDRESSWIDTH  registered address of if_id_instr_o.
- if_id_valid_o  output  1  registered; 1 = real instruction, 0 = bubble.
- halted_o  output  1  fetch stopped on HALT.
- fetch_err_o  output  1  sticky; an INVALID_WORD was fetched while not suppressed.
- fetch_count_o  output  32  count of valid instructions delivered to IF/ID.

Function
REQ-007 SHALL drive imem_addr_o combinationally from the PC register and imem_branch_taken_o combinationally equal to branch_taken_i.
REQ-008 SHALL implement states RUN and HALTED.
REQ-009 Priority per cycle SHALL be: branch_taken_i > stall_i > normal advance, in both states.
REQ-010 branch_taken_i=1: PC <= branch_target_i; IF/ID <= instr 0, pc 0, valid 0; state <= RUN (including from HALTED); halted_o cleared next cycle.
REQ-011 stall_i=1, no branch: PC, IF/ID, fetch_count_o and fetch_err_o SHALL hold.
REQ-012 RUN advance with imem_instr_i != INVALID_WORD: IF/ID <= {imem_instr_i, PC, valid 1}; PC <= PC+4, wrapping modulo 2^ADDRESSWIDTH; fetch_count_o increments.
REQ-013 RUN advance with imem_instr_i == INVALID_WORD: IF/ID <= bubble (instr 0, valid 0); PC <= PC+4; fetch_err_o <= 1; count unchanged.
REQ-014 RUN advance with imem_instr_i[31:26] == HALT_OPCODE: HALT SHALL be latched into IF/ID valid 1 and counted; PC holds; state <= HALTED.
REQ-015 HALTED without branch: PC holds; IF/ID <= bubble every cycle; halted_o=1; stall_i ignored.
REQ-016 fetch_count_o SHALL saturate at 32'hFFFF_FFFF.
REQ-017 fetch_err_o SHALL clear only on reset.

Reset
REQ-018 While rst_n=0, asynchronously: PC=RESET_PC, state RUN, if_id_instr_o=0, if_id_pc_o=0, if_id_valid_o=0, halted_o=0, fetch_err_o=0, fetch_count_o=0.
REQ-019 Reset asserted mid-stall, mid-redirect or in HALTED SHALL yield REQ-018 values; first fetch after release SHALL be at RESET_PC.

Verification
REQ-020 Sequential: memory words 0x20010005, 0x20020003, 0x00221820 at 0,4,8 -> IF/ID valid 1 with pc 0,4,8 on cycles 1-3 after release; fetch_count_o=3.
REQ-021 Stall: stall_i=1 for 2 cycles at PC=8 -> IF/ID, PC, count frozen; resume delivers pc 8 next.
REQ-022 Branch with simultaneous stall: branch_taken_i=1, stall_i=1, target 0x40 at PC=0x10 -> imem_branch_taken_o=1, bubble next cycle, following IF/ID pc 0x40 valid 1.
REQ-023 HALT: opcode 0x11 at 0x0C -> HALT valid at pc 0x0C, halted_o=1, then bubbles; later branch_taken_i target 0x20 -> RUN, pc 0x20 delivered.
REQ-024 Misaligned target 0x42 -> memory returns INVALID_WORD -> bubble, fetch_err_o=1 sticky, PC advances to 0x46.
REQ-025 Async reset pulse while HALTED with fetch_count_o=7 -> all outputs to REQ-018 values immediately, first fetch at RESET_PC.
